// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port bit-masked SRAM macro.
// Drives the macro BIST port and reports pass/fail with first-fail diagnostics.
module sram_march_bist #(
   parameter int                ADDR_W = 9,
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              bist_en_o,
   output logic              bist_men_o,
   output logic              bist_wen_o,
   output logic              bist_ren_o,
   output logic [ADDR_W-1:0] bist_addr_o,
   output logic [DATA_W-1:0] bist_din_o,
   output logic [DATA_W-1:0] bist_bm_o,
   input  logic [DATA_W-1:0] sram_dout_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o,
   output logic [15:0]       fail_cnt_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] A_MIN = {ADDR_W{1'b0}};

   logic [1:0]        state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              cmp_vld_q, cmp_vld_d;
   logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
   logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
   logic [2:0]        cmp_elem_q, cmp_elem_d;

   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [2:0]        felem_q, felem_d;
   logic [15:0]       fcnt_q, fcnt_d;

   logic run, drain, idle_like;
   logic desc, two_op, is_rd, rd_inv, wr_inv;
   logic last_op, last_addr, miscmp, clr;

   assign run       = (state_q == S_RUN);
   assign drain     = (state_q == S_DRAIN);
   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

   // Elements 1..4 are read-then-write; 0 is write-only, 5 is read-only.
   assign desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign two_op    = (elem_q != 3'd0) && (elem_q != 3'd5);
   assign is_rd     = (elem_q == 3'd5) || (two_op && !op_q);
   assign rd_inv    = (elem_q == 3'd2) || (elem_q == 3'd4);
   assign wr_inv    = (elem_q == 3'd1) || (elem_q == 3'd3);
   assign last_op   = !two_op || op_q;
   assign last_addr = desc ? (addr_q == A_MIN) : (addr_q == A_MAX);

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      op_d    = op_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               op_d    = 1'b0;
               addr_d  = A_MIN;
            end
         end
         S_RUN: begin
            if (!last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!last_addr) begin
                  addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
               end else if (elem_q == 3'd5) begin
                  state_d = S_DRAIN;
               end else begin
                  elem_d = elem_q + 3'd1;
                  addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3))
                           ? A_MAX : A_MIN;
               end
            end
         end
         default: state_d = S_DONE;
      endcase
   end

   assign cmp_vld_d  = run && is_rd;
   assign cmp_exp_d  = rd_inv ? ~BG : BG;
   assign cmp_addr_d = addr_q;
   assign cmp_elem_d = elem_q;

   assign miscmp = cmp_vld_q && (sram_dout_i != cmp_exp_q);
   assign clr    = idle_like && start_i;

   always_comb begin
      fail_d  = fail_q;
      faddr_d = faddr_q;
      felem_d = felem_q;
      fcnt_d  = fcnt_q;
      if (clr) begin
         fail_d  = 1'b0;
         faddr_d = A_MIN;
         felem_d = 3'd0;
         fcnt_d  = 16'd0;
      end else if (miscmp) begin
         if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
         if (!fail_q) begin
            fail_d  = 1'b1;
            faddr_d = cmp_addr_q;
            felem_d = cmp_elem_q;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         elem_q     <= 3'd0;
         op_q       <= 1'b0;
         addr_q     <= A_MIN;
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_addr_q <= A_MIN;
         cmp_elem_q <= 3'd0;
         fail_q     <= 1'b0;
         faddr_q    <= A_MIN;
         felem_q    <= 3'd0;
         fcnt_q     <= 16'd0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_exp_q  <= cmp_exp_d;
         cmp_addr_q <= cmp_addr_d;
         cmp_elem_q <= cmp_elem_d;
         fail_q     <= fail_d;
         faddr_q    <= faddr_d;
         felem_q    <= felem_d;
         fcnt_q     <= fcnt_d;
      end
   end

   // DRAIN keeps the BIST port selected so the last read data returns.
   assign bist_en_o   = run || drain;
   assign busy_o      = run || drain;
   assign done_o      = (state_q == S_DONE);
   assign bist_bm_o   = bist_en_o ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
   assign bist_men_o  = run;
   assign bist_wen_o  = run && !is_rd;
   assign bist_ren_o  = run && is_rd;
   assign bist_addr_o = run ? addr_q : A_MIN;
   assign bist_din_o  = (run && !is_rd) ? (wr_inv ? ~BG : BG)
                                        : {DATA_W{1'b0}};
   assign fail_o      = fail_q;
   assign fail_addr_o = faddr_q;
   assign fail_elem_o = felem_q;
   assign fail_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist with a fault-injectable SRAM model.
// Expected run results are queued by stimulus and popped when done_o rises.
module tb_sram_march_bist;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int N  = 512;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
   logic [AW-1:0] bist_addr_o;
   logic [DW-1:0] bist_din_o, bist_bm_o;
   logic [DW-1:0] sram_dout_i;
   logic          busy_o, done_o, fail_o;
   logic [AW-1:0] fail_addr_o;
   logic [2:0]    fail_elem_o;
   logic [15:0]   fail_cnt_o;

   sram_march_bist dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .bist_en_o(bist_en_o), .bist_men_o(bist_men_o),
      .bist_wen_o(bist_wen_o), .bist_ren_o(bist_ren_o),
      .bist_addr_o(bist_addr_o), .bist_din_o(bist_din_o),
      .bist_bm_o(bist_bm_o), .sram_dout_i(sram_dout_i),
      .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
      .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o),
      .fail_cnt_o(fail_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // 0 fault-free, 1 stuck-at-1 bit7 @0x1A5, 2 coupling 0x010->0x011, 3 invert
   int fault = 0;
   logic [DW-1:0] mem [N];

   always @(posedge clk_i) begin
      if (bist_en_o && bist_men_o) begin
         if (bist_wen_o) begin
            mem[bist_addr_o] <= (mem[bist_addr_o] & ~bist_bm_o)
                              | (bist_din_o & bist_bm_o);
            if (fault == 2 && bist_addr_o == 9'h010)
               mem[9'h011] <= mem[9'h011] ^ 32'h1;
         end
         if (bist_ren_o) begin
            if (fault == 1 && bist_addr_o == 9'h1A5)
               sram_dout_i <= mem[bist_addr_o] | 32'h80;
            else if (fault == 3)
               sram_dout_i <= ~mem[bist_addr_o];
            else
               sram_dout_i <= mem[bist_addr_o];
         end
      end
   end

   typedef struct {
      bit            fail;
      logic [AW-1:0] addr;
      logic [2:0]    elem;
      logic [15:0]   cnt;
      int            busy;
   } exp_t;

   typedef struct {
      logic          wen;
      logic          ren;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } op_t;

   exp_t sb_q[$];
   op_t  tr_q[$];
   int   checks = 0;
   int   errors = 0;
   int   bcnt   = 0;
   logic done_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      op_t  o;
      if (bist_men_o && tr_q.size() > 0) begin
         o = tr_q.pop_front();
         chk("trace_wen", 32'(bist_wen_o), 32'(o.wen));
         chk("trace_ren", 32'(bist_ren_o), 32'(o.ren));
         chk("trace_addr", 32'(bist_addr_o), 32'(o.addr));
         chk("trace_din", bist_din_o, o.din);
         chk("trace_bm", bist_bm_o, 32'hFFFF_FFFF);
      end
      if (done_o && !done_prev) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("busy_cycles", 32'(bcnt), 32'(e.busy));
            chk("fail", 32'(fail_o), 32'(e.fail));
            chk("fail_addr", 32'(fail_addr_o), 32'(e.addr));
            chk("fail_elem", 32'(fail_elem_o), 32'(e.elem));
            chk("fail_cnt", 32'(fail_cnt_o), 32'(e.cnt));
         end
      end
      done_prev = done_o;
      if (busy_o) bcnt++;
      else bcnt = 0;
   end

   task automatic push_trace();
      op_t o;
      int  a;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a = (e == 3 || e == 4) ? N - 1 - i : i;
            o.addr = AW'(a);
            if (e != 0) begin
               o.wen = 1'b0; o.ren = 1'b1; o.din = '0;
               tr_q.push_back(o);
            end
            if (e != 5) begin
               o.wen = 1'b1; o.ren = 1'b0;
               o.din = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
               tr_q.push_back(o);
            end
         end
      end
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk_i);
         if (done_o) return;
      end
      chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic run_one(input string nm, input exp_t e, input bit tr);
      if (tr) push_trace();
      sb_q.push_back(e);
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      wait_done(nm);
      chk({nm, "_done_port"},
          {29'd0, bist_en_o, busy_o, bist_men_o}, 32'd0);
   endtask

   function automatic exp_t mk(input bit f, input logic [AW-1:0] a,
                               input logic [2:0] el, input logic [15:0] c);
      exp_t e;
      e.fail = f; e.addr = a; e.elem = el; e.cnt = c; e.busy = 10 * N + 1;
      return e;
   endfunction

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("reset_ctl", {26'd0, bist_en_o, bist_men_o, bist_wen_o,
                        bist_ren_o, busy_o, done_o}, 32'd0);
      chk("reset_status", {fail_o, fail_addr_o, fail_elem_o, fail_cnt_o},
          32'd0);
      chk("reset_bm", bist_bm_o, 32'd0);
      rst_i = 1'b0;

      fault = 0;
      run_one("clean", mk(1'b0, 9'h000, 3'd0, 16'd0), 1'b1);
      chk("trace_left", 32'(tr_q.size()), 32'd0);

      fault = 1;
      run_one("stuck", mk(1'b1, 9'h1A5, 3'd1, 16'd3), 1'b0);

      fault = 2;
      run_one("couple", mk(1'b1, 9'h011, 3'd1, 16'd4), 1'b0);

      fault = 0;
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      repeat (1999) @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("rst_mid_ctl", {26'd0, bist_en_o, bist_men_o, bist_wen_o,
                          bist_ren_o, busy_o, done_o}, 32'd0);
      chk("rst_mid_bus", bist_addr_o | bist_din_o | bist_bm_o, 32'd0);
      chk("rst_mid_status", {fail_o, fail_addr_o, fail_elem_o, fail_cnt_o},
          32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      run_one("after_rst", mk(1'b0, 9'h000, 3'd0, 16'd0), 1'b0);

      fault = 1;
      sb_q.push_back(mk(1'b1, 9'h1A5, 3'd1, 16'd3));
      sb_q.push_back(mk(1'b1, 9'h1A5, 3'd1, 16'd3));
      @(negedge clk_i);
      start_i = 1'b1;
      wait_done("held1");
      chk("held1_fail", 32'(fail_o), 32'd1);
      @(posedge clk_i);
      #1;
      chk("held_restart_busy", {30'd0, busy_o, done_o}, 32'd2);
      chk("held_restart_clr", {fail_o, fail_addr_o, fail_elem_o, fail_cnt_o},
          32'd0);
      wait_done("held2");
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("held_done_kept", {30'd0, done_o, busy_o}, 32'd2);
      chk("held_cnt_kept", 32'(fail_cnt_o), 32'd3);

      fault = 3;
      run_one("invert", mk(1'b1, 9'h000, 3'd1, 16'd2560), 1'b0);

      repeat (2) @(negedge clk_i);
      chk("sb_left", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
